// File: rtl/inst_mem_resp_pkg.sv
// Shared constants and FSM encoding for the instruction-memory responder.
// The IMEM_ALIGN_CHK_EN macro (see inst_mem_resp.sv) does not affect this package.
package inst_mem_resp_pkg;

    localparam logic [31:0] ZeroWord   = 32'h0000_0000;
    localparam logic        RstEnable  = 1'b1;
    localparam logic        ChipEnable = 1'b1;
    localparam logic        Stop       = 1'b1;
    localparam logic        NoStop     = 1'b0;
    localparam int          InstBus    = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        HOLD   = 2'd2
    } fsm_state_t;

    // True when the byte address reaches past the implemented word range.
    function automatic logic addr_out_of_range(input logic [31:0] a, input int aw);
        return (a >> (aw + 2)) != 32'd0;
    endfunction

endpackage

// File: rtl/inst_mem_resp_imem_array.sv
// Instruction storage: registered read with enable, independent write port, read-first.
module imem_array #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata
);

    logic [DATA_WIDTH-1:0] mem [0:(2**ADDR_WIDTH)-1];

    // Both updates are non-blocking, so a same-word read sees the pre-write value.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/inst_mem_resp.sv
// Instruction fetch responder: wait-state FSM over imem_array with stall hold and abort.
// Define IMEM_ALIGN_CHK_EN to flag non-word-aligned fetches via misalign.
module inst_mem_resp
    import inst_mem_resp_pkg::*;
#(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce,
    input  logic [31:0]           addr,
    input  logic [5:0]            stall,
    input  logic                  ld_we,
    input  logic [ADDR_WIDTH-1:0] ld_addr,
    input  logic [31:0]           ld_data,
    output logic [31:0]           inst,
    output logic                  inst_valid,
    output logic                  stallreq_if,
    output logic                  misalign
);

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    fsm_state_t            state_reg;
    logic [3:0]            cnt_reg;
    logic [ADDR_WIDTH-1:0] word_reg;
    logic                  hi_bad_reg;
    logic                  lo_bad_reg;
    logic                  inst_en_reg;
    logic                  inst_valid_reg;
    logic                  misalign_reg;

    logic [InstBus-1:0]    rdata;
    logic                  respond;
    logic                  capture;
    logic                  addr_lo_bad;
    logic                  unused_bits;

`ifdef IMEM_ALIGN_CHK_EN
    assign addr_lo_bad = addr[1:0] != 2'b00;
`else
    assign addr_lo_bad = 1'b0;
`endif

    assign unused_bits = ^{stall[5:2], stall[0], addr[1:0]};

    always_comb begin
        respond = (state_reg == ACCESS) && (ce == ChipEnable) && (cnt_reg == 4'd0);
        capture = 1'b0;
        case (state_reg)
            IDLE:    capture = (ce == ChipEnable);
            ACCESS:  capture = respond && (stall[1] == NoStop);
            HOLD:    capture = (stall[1] == NoStop) && (ce == ChipEnable);
            default: capture = 1'b0;
        endcase
    end

    // The array's output register doubles as the inst register; it only loads on a response.
    imem_array #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (InstBus)
    ) u_array (
        .clk   (clk),
        .re    (respond),
        .raddr (word_reg),
        .rdata (rdata),
        .we    (ld_we),
        .waddr (ld_addr),
        .wdata (ld_data)
    );

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_reg      <= IDLE;
            cnt_reg        <= 4'd0;
            word_reg       <= '0;
            hi_bad_reg     <= 1'b0;
            lo_bad_reg     <= 1'b0;
            inst_en_reg    <= 1'b0;
            inst_valid_reg <= 1'b0;
            misalign_reg   <= 1'b0;
        end else begin
            inst_valid_reg <= 1'b0;
            misalign_reg   <= 1'b0;
            case (state_reg)
                IDLE: begin
                    inst_en_reg <= 1'b0;
                end
                ACCESS: begin
                    if (ce != ChipEnable) begin
                        state_reg   <= IDLE;
                        cnt_reg     <= 4'd0;
                        inst_en_reg <= 1'b0;
                    end else if (cnt_reg != 4'd0) begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end else begin
                        inst_valid_reg <= 1'b1;
                        misalign_reg   <= lo_bad_reg;
                        inst_en_reg    <= !hi_bad_reg && !lo_bad_reg;
                        if (stall[1] == Stop) begin
                            state_reg <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (stall[1] == NoStop && ce != ChipEnable) begin
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
            // A new fetch overrides whichever transition the case chose.
            if (capture) begin
                state_reg  <= ACCESS;
                cnt_reg    <= WAIT_INIT;
                word_reg   <= addr[ADDR_WIDTH+1:2];
                hi_bad_reg <= addr_out_of_range(addr, ADDR_WIDTH);
                lo_bad_reg <= addr_lo_bad;
            end
        end
    end

    assign inst        = inst_en_reg ? rdata : ZeroWord;
    assign inst_valid  = inst_valid_reg;
    assign misalign    = misalign_reg;
    assign stallreq_if = (state_reg == ACCESS) && (cnt_reg != 4'd0);

endmodule

// File: tb/tb_inst_mem_resp.sv
// Bench: two responders (0 and 1 wait states) on shared stimulus, checked against a
// transaction-level model that predicts each response from its capture edge plus latency.
module tb_inst_mem_resp;

    localparam int AW    = 10;
    localparam int NLOAD = 64;
`ifdef IMEM_ALIGN_CHK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst, ce, ld_we;
    logic [31:0]   addr, ld_data;
    logic [5:0]    stall;
    logic [AW-1:0] ld_addr;
    logic [31:0]   inst0, inst1;
    logic          v0, v1, s0, s1, m0, m1;

    always #5 clk = ~clk;

    inst_mem_resp #(.ADDR_WIDTH(AW), .WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .rst(rst), .ce(ce), .addr(addr), .stall(stall),
        .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
        .inst(inst0), .inst_valid(v0), .stallreq_if(s0), .misalign(m0)
    );

    inst_mem_resp #(.ADDR_WIDTH(AW), .WAIT_CYCLES(1)) u_w1 (
        .clk(clk), .rst(rst), .ce(ce), .addr(addr), .stall(stall),
        .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
        .inst(inst1), .inst_valid(v1), .stallreq_if(s1), .misalign(m1)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: index 0 -> 0 wait states, index 1 -> 1 wait state.
    logic [31:0]   ref_mem [0:1023];
    int            edge_n = 0;
    int            waits [2] = '{0, 1};
    bit            m_pend [2];
    bit            m_hold [2];
    int            m_due [2];
    logic [AW-1:0] m_word [2];
    bit            m_hi [2];
    bit            m_lo [2];
    logic [31:0]   e_inst [2];
    bit            e_valid [2];
    bit            e_mis [2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic capture(input int i);
        m_pend[i] = 1'b1;
        m_hold[i] = 1'b0;
        m_due[i]  = edge_n + 1 + waits[i];
        m_word[i] = addr[AW+1:2];
        m_hi[i]   = (addr >> (AW + 2)) != 0;
        m_lo[i]   = ALIGN && (addr[1:0] != 2'b00);
    endtask

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            e_valid[i] = 1'b0;
            e_mis[i]   = 1'b0;
            if (rst) begin
                m_pend[i] = 1'b0;
                m_hold[i] = 1'b0;
                e_inst[i] = 32'h0;
            end else if (m_pend[i]) begin
                if (!ce) begin
                    m_pend[i] = 1'b0;
                    e_inst[i] = 32'h0;
                end else if (edge_n == m_due[i]) begin
                    e_valid[i] = 1'b1;
                    e_mis[i]   = m_lo[i];
                    e_inst[i]  = (m_hi[i] || m_lo[i]) ? 32'h0 : ref_mem[m_word[i]];
                    m_pend[i]  = 1'b0;
                    if (stall[1]) m_hold[i] = 1'b1;
                    else          capture(i);
                end
            end else if (m_hold[i]) begin
                if (!stall[1]) begin
                    m_hold[i] = 1'b0;
                    if (ce) capture(i);
                end
            end else begin
                e_inst[i] = 32'h0;
                if (ce) capture(i);
            end
        end
        if (ld_we) ref_mem[ld_addr] = ld_data;
        edge_n++;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("inst_w%0d@%0d", waits[i], edge_n), (i == 0) ? inst0 : inst1, e_inst[i]);
            check($sformatf("valid_w%0d@%0d", waits[i], edge_n), 32'((i == 0) ? v0 : v1), 32'(e_valid[i]));
            check($sformatf("mis_w%0d@%0d", waits[i], edge_n), 32'((i == 0) ? m0 : m1), 32'(e_mis[i]));
            check($sformatf("streq_w%0d@%0d", waits[i], edge_n), 32'((i == 0) ? s0 : s1),
                  32'(m_pend[i] && (m_due[i] > edge_n)));
        end
    endtask

    logic [31:0] held, old5, new5;

    initial begin
        rst = 1'b1; ce = 1'b0; addr = 32'h0; stall = 6'h0;
        ld_we = 1'b0; ld_addr = '0; ld_data = 32'h0;

        // Load memory while reset is held.
        for (int k = 0; k < NLOAD; k++) begin
            ld_we   = 1'b1;
            ld_addr = k[AW-1:0];
            ld_data = (k == 0) ? 32'h3401_0020 : $urandom;
            cycle();
        end
        ld_we = 1'b0;
        cycle();
        check("rst_inst", inst1, 32'h0);
        rst = 1'b0;
        cycle();

        // Reset-then-fetch, one wait state.
        ce = 1'b1; addr = 32'h0;
        cycle();
        check("r30_streq_hi", 32'(s1), 32'd1);
        cycle();
        check("r30_streq_lo", 32'(s1), 32'd0);
        cycle();
        check("r30_valid", 32'(v1), 32'd1);
        check("r30_inst", inst1, 32'h3401_0020);

        // Back-to-back on the zero-wait instance.
        addr = 32'h0; cycle();
        addr = 32'h4; cycle();
        check("b2b_0", inst0, ref_mem[0]);
        addr = 32'h8; cycle();
        check("b2b_1", inst0, ref_mem[1]);
        cycle();
        check("b2b_2", inst0, ref_mem[2]);
        check("b2b_valid", 32'(v0), 32'd1);

        // Stall hold for three cycles.
        stall = 6'b000010;
        cycle();
        held = inst0;
        cycle();
        check("hold_valid", 32'(v0), 32'd0);
        cycle();
        check("hold_inst", inst0, held);
        stall = 6'h0;
        cycle(); cycle();

        // Abort mid-access.
        ce = 1'b0; cycle(); cycle();
        ce = 1'b1; addr = 32'hC; cycle();
        ce = 1'b0; cycle();
        check("abort_inst", inst1, 32'h0);
        cycle();
        check("abort_valid", 32'(v1), 32'd0);

        // Reset mid-access, then refetch to confirm memory survives.
        ce = 1'b1; addr = 32'h10; cycle();
        rst = 1'b1; cycle();
        check("rst_mid_all", {inst1[31:3], v1, s1, m1}, 32'h0);
        rst = 1'b0; ce = 1'b0; cycle();
        ce = 1'b1; addr = 32'h10; cycle(); cycle(); cycle();
        check("rst_mem_intact", inst1, ref_mem[4]);

        // Write collision on word 5 at the response edge.
        ce = 1'b0; cycle();
        ce = 1'b1; addr = 32'h14; cycle(); cycle();
        old5 = ref_mem[5];
        new5 = ~old5;
        ld_we = 1'b1; ld_addr = 10'd5; ld_data = new5;
        cycle();
        ld_we = 1'b0;
        check("coll_old", inst1, old5);
        cycle(); cycle();
        check("coll_new", inst1, new5);

        // Out-of-range address.
        ce = 1'b0; cycle();
        ce = 1'b1; addr = 32'h0001_0000; cycle(); cycle(); cycle();
        check("range_valid", 32'(v1), 32'd1);
        check("range_inst", inst1, 32'h0);

        // Misaligned address.
        ce = 1'b0; cycle();
        ce = 1'b1; addr = 32'h6; cycle(); cycle(); cycle();
        check("align_inst", inst1, ALIGN ? 32'h0 : ref_mem[1]);
        check("align_mis", 32'(m1), 32'(ALIGN));

        // Randomised traffic.
        for (int n = 0; n < 600; n++) begin
            rst      = ($urandom_range(0, 99) == 0);
            ce       = ($urandom_range(0, 9) != 0);
            stall    = 6'($urandom);
            stall[1] = ($urandom_range(0, 3) == 0);
            addr     = {$urandom_range(0, 15) == 0 ? 12'h001 : 12'h000, 8'h00,
                        6'($urandom_range(0, NLOAD - 1)), 2'($urandom)};
            ld_we    = ($urandom_range(0, 3) == 0);
            ld_addr  = AW'($urandom_range(0, NLOAD - 1));
            ld_data  = $urandom;
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/inst_mem_resp.md
INST_MEM_RESP -- requirements
Module: inst_mem_resp

Interface
REQ-001 SHALL provide parameter ADDR_WIDTH, default 10, giving the word-address width (1024 x 32-bit words).
REQ-002 SHALL provide parameter WAIT_CYCLES, default 1, giving the extra access wait states (legal range 0..15).
REQ-003 SHALL provide port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL provide port rst, input, 1, reset, synchronous and active-high (RstEnable = 1).
REQ-005 SHALL provide port ce, input, 1, fetch-chip-enable from the PC stage.
REQ-006 SHALL provide port addr, input, 32, byte address of the instruction (pc).
REQ-007 SHALL provide port stall, input, 6, pipeline stall vector; stall[1] = IF/ID hold.
REQ-008 SHALL provide ports ld_we (input, 1), ld_addr (input, ADDR_WIDTH) and ld_data (input, 32), the word-write loader port.
REQ-009 SHALL provide port inst, output, 32, the fetched instruction.
REQ-010 SHALL provide port inst_valid, output, 1, high for each cycle that inst is a new response.
REQ-011 SHALL provide port stallreq_if, output, 1, request to the stall controller while an access is pending.
REQ-012 SHALL provide port misalign, output, 1, alignment-error flag qualified by inst_valid.

Function
REQ-013 SHALL implement FSM states IDLE, ACCESS and HOLD.
REQ-014 In IDLE with ce=0, SHALL drive inst=ZeroWord, inst_valid=0 and stallreq_if=0.
REQ-015 In IDLE with ce=1, SHALL latch addr[ADDR_WIDTH+1:2], load wait counter = WAIT_CYCLES and enter ACCESS.
REQ-016 In ACCESS with counter != 0, SHALL decrement the counter and drive stallreq_if=1 combinationally.
REQ-017 In ACCESS with counter == 0, SHALL register inst <= mem[latched] and pulse inst_valid for one cycle; with stallreq_if=0, response latency from addr capture is 1+WAIT_CYCLES cycles.
REQ-018 On response, if stall[1]=Stop, SHALL enter HOLD; otherwise, if ce=1, SHALL recapture addr and reload the counter (back-to-back fetch), else SHALL enter IDLE.
REQ-019 In HOLD, SHALL keep inst stable with inst_valid=0 until stall[1]=NoStop, then behave as the post-response step of REQ-018.
REQ-020 If ce falls during ACCESS, SHALL abort, enter IDLE and drive inst=ZeroWord on the next cycle with no inst_valid pulse.
REQ-021 If any addr bit above ADDR_WIDTH+1 is set, SHALL return inst=ZeroWord (NOP) with normal timing.
REQ-022 Loader writes SHALL take effect at the clock edge; a read of the same word in the same cycle SHALL return the old data (read-first).
REQ-023 Loader writes SHALL be accepted in every state, including during reset.

Reset
REQ-024 On rst=1 at a clock edge, SHALL enter IDLE, clear the counter and drive inst=ZeroWord, inst_valid=0, stallreq_if=0 and misalign=0; memory contents SHALL be preserved.
REQ-025 Reset asserted mid-ACCESS or mid-HOLD SHALL discard the pending response.

Configuration
REQ-026 With IMEM_ALIGN_CHK_EN defined, a captured addr[1:0] != 0 SHALL yield inst=ZeroWord and misalign=1 with the inst_valid pulse.
REQ-027 Without IMEM_ALIGN_CHK_EN, addr[1:0] SHALL be ignored and misalign SHALL be tied 0; the port list SHALL be unchanged.

Structure
REQ-028 FSM state encodings and the existing ZeroWord, RstEnable, ChipEnable, Stop, NoStop and InstBus constants SHALL live in the shared defines header.
REQ-029 Storage SHALL be a sub-module imem_array: single-port synchronous read, separate synchronous write port, read-first behaviour.

Verification
REQ-030 Reset-then-fetch: WAIT_CYCLES=1, mem[0]=0x3401_0020, ce=1, addr=0 -> stallreq_if high 1 cycle, inst=0x3401_0020 with inst_valid on cycle 2.
REQ-031 Back-to-back fetch: WAIT_CYCLES=0, addr 0,4,8 on consecutive cycles -> inst_valid every cycle with mem[0], mem[1], mem[2] in order and stallreq_if never high.
REQ-032 Stall hold: stall[1]=Stop for 3 cycles at a response -> inst held constant, inst_valid=0, then the next fetch resumes.
REQ-033 Abort and reset: ce dropped mid-ACCESS -> inst=0 next cycle and no pulse; rst mid-ACCESS -> all outputs 0 and memory intact.
REQ-034 Write collision and range: ld_we to word 5 while reading word 5 -> old value returned, new value on refetch; addr=0x0001_0000 -> inst=0.
REQ-035 Alignment check: with IMEM_ALIGN_CHK_EN, addr=0x6 -> misalign=1 and inst=0; without the macro -> mem[1] returned and misalign=0.
